// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad scanner matrix and key-report signal bundle
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] column;
    logic [3:0] row;
    logic       key_valid;
    logic       key_held;

    // Scanner side: reads rows, drives columns and reports keys
    modport master (
        input  row_in,
        output col_drive,
        output column,
        output row,
        output key_valid,
        output key_held
    );

    // Consumer / keypad side
    modport slave (
        output row_in,
        input  col_drive,
        input  column,
        input  row,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state;
    logic [3:0]    sync1;
    logic [3:0]    rs;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt;
    logic [1:0]    col_idx;
    logic [1:0]    cap_row;
    logic [3:0]    col_drive_q;
    logic [1:0]    column_q;
    logic [1:0]    row_q;
    logic          key_valid_q;
    logic          key_held_q;

    // Lowest-index active-low row wins when several rows are down
    function automatic logic [1:0] first_low(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // Active-low one-hot drive pattern for a column index
    function automatic logic [3:0] drive_of(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Two-flop synchroniser for the asynchronous row lines; idle level is all-high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b1111;
            rs    <= 4'b1111;
        end else begin
            sync1 <= kp.row_in;
            rs    <= sync1;
        end
    end

    // Scan / debounce / hold / release state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            dwell       <= '0;
            cnt         <= '0;
            col_idx     <= 2'd0;
            cap_row     <= 2'd0;
            col_drive_q <= 4'b1110;
            column_q    <= 2'd0;
            row_q       <= 2'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (rs == 4'b1111) begin
                            col_idx     <= col_idx + 2'd1;
                            col_drive_q <= drive_of(col_idx + 2'd1);
                        end else begin
                            cap_row <= first_low(rs);
                            cnt     <= '0;
                            state   <= DEBOUNCE;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs[cap_row]) begin
                        // Bounce: abandon this key and move on without touching outputs
                        state       <= SCAN;
                        dwell       <= '0;
                        cnt         <= '0;
                        col_idx     <= col_idx + 2'd1;
                        col_drive_q <= drive_of(col_idx + 2'd1);
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        column_q    <= col_idx;
                        row_q       <= cap_row;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (rs == 4'b1111) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
                end
                RELEASE: begin
                    if (rs != 4'b1111) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= SCAN;
                        cnt         <= '0;
                        dwell       <= '0;
                        key_held_q  <= 1'b0;
                        col_idx     <= col_idx + 2'd1;
                        col_drive_q <= drive_of(col_idx + 2'd1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign kp.col_drive = col_drive_q;
    assign kp.column    = {2'b00, column_q};
    assign kp.row       = {2'b00, row_q};
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   kv_count;
    logic keys [4][4];
    logic [3:0] row_model;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_model = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c][r] && !kp.col_drive[c]) row_model[r] = 1'b0;
    end
    assign kp.row_in = row_model;

    always @(negedge clk) if (!rst && kp.key_valid) kv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_kv(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (kp.key_valid) found = 1'b1;
        end
        check({tag, "_kv_seen"}, found, 1'b1);
    endtask

    task automatic wait_release(input string tag, output int n);
        logic done = 1'b0;
        n = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            n++;
            if (!kp.key_held) done = 1'b1;
        end
        check({tag, "_released"}, done, 1'b1);
    endtask

    task automatic wait_col(input logic [3:0] drv);
        for (int i = 0; i < 100 && kp.col_drive != drv; i++) @(negedge clk);
        check("wait_col", kp.col_drive, drv);
    endtask

    initial begin
        int n;
        int base;
        logic [3:0] exp_drv;
        checks   = 0;
        failures = 0;
        kv_count = 0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) keys[c][r] = 1'b0;

        // 1: reset values and free-running scan sequence
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_drive", kp.col_drive, 4'b1110);
        check("rst_column", kp.column, 4'd0);
        check("rst_row", kp.row, 4'd0);
        check("rst_key_valid", kp.key_valid, 1'b0);
        check("rst_key_held", kp.key_held, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            case ((i / 4) % 4)
                0: exp_drv = 4'b1110;
                1: exp_drv = 4'b1101;
                2: exp_drv = 4'b1011;
                default: exp_drv = 4'b0111;
            endcase
            check("scan_step", kp.col_drive, exp_drv);
        end

        // 2: single key at column 2 row 2
        base = kv_count;
        wait_col(4'b1011);
        keys[2][2] = 1'b1;
        wait_kv("single");
        check("single_column", kp.column, 4'd2);
        check("single_row", kp.row, 4'd2);
        check("single_held", kp.key_held, 1'b1);
        repeat (20) @(negedge clk);
        check("single_kv_once", kv_count, base + 1);
        check("single_still_held", kp.key_held, 1'b1);
        keys[2][2] = 1'b0;
        wait_release("single", n);
        check("single_release_delay", n >= 8, 1'b1);
        check("single_next_col", kp.col_drive, 4'b0111);

        // 3: press bounce on column 1 row 1
        base = kv_count;
        wait_col(4'b1101);
        keys[1][1] = 1'b1;
        repeat (6) @(negedge clk);
        keys[1][1] = 1'b0;
        repeat (4) @(negedge clk);
        check("bounce_advance", kp.col_drive, 4'b1011);
        repeat (20) @(negedge clk);
        check("bounce_no_kv", kv_count, base);
        check("bounce_column", kp.column, 4'd2);
        check("bounce_row", kp.row, 4'd2);

        // 4: release bounce on column 3 row 0
        base = kv_count;
        keys[3][0] = 1'b1;
        wait_kv("relb");
        check("relb_column", kp.column, 4'd3);
        check("relb_row", kp.row, 4'd0);
        repeat (3) @(negedge clk);
        keys[3][0] = 1'b0;
        repeat (4) @(negedge clk);
        keys[3][0] = 1'b1;
        repeat (20) @(negedge clk);
        check("relb_held", kp.key_held, 1'b1);
        check("relb_kv_once", kv_count, base + 1);
        keys[3][0] = 1'b0;
        wait_release("relb", n);

        // 5: two rows low in column 0, lowest row wins
        base = kv_count;
        keys[0][1] = 1'b1;
        keys[0][3] = 1'b1;
        wait_kv("multi");
        check("multi_column", kp.column, 4'd0);
        check("multi_row", kp.row, 4'd1);
        keys[0][1] = 1'b0;
        keys[0][3] = 1'b0;
        wait_release("multi", n);
        check("multi_kv_once", kv_count, base + 1);

        // 6: reset during debounce
        base = kv_count;
        wait_col(4'b1101);
        keys[1][0] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstdb_col_drive", kp.col_drive, 4'b1110);
        check("rstdb_key_valid", kp.key_valid, 1'b0);
        check("rstdb_key_held", kp.key_held, 1'b0);
        check("rstdb_column", kp.column, 4'd0);
        keys[1][0] = 1'b0;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rstdb_no_kv", kv_count, base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
